// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character LCD controller:
// top-level sequencer states, byte-writer phases, panel command bytes and
// the power-on initialisation order.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT,
    S_L1_ADDR,
    S_L1_CHAR,
    S_L2_ADDR,
    S_L2_CHAR,
    S_IDLE
  } lcd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SETUP,
    W_PULSE,
    W_WAIT
  } wr_phase_t;

  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
  localparam logic [7:0] CMD_ROW1      = 8'h80;
  localparam logic [7:0] CMD_ROW2      = 8'hC0;

  // Index of the final init command; reaching it ends initialisation.
  localparam logic [2:0] INIT_LAST = 3'd5;

  // First table entry of row 2; seeing it as the next address ends row 1.
  localparam logic [4:0] ROW2_FIRST = 5'd16;

  // Power-on init order: function set three times, display on, clear, entry mode.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    logic [7:0] cmd;
    cmd = CMD_FUNC_8B2L;
    case (idx)
      3'd0, 3'd1, 3'd2: cmd = CMD_FUNC_8B2L;
      3'd3:             cmd = CMD_DISP_ON;
      3'd4:             cmd = CMD_CLEAR;
      3'd5:             cmd = CMD_ENTRY_INC;
      default:          cmd = CMD_FUNC_8B2L;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_escritura.sv
// One timed HD44780 byte write: a setup cycle with E low, T_E cycles of E
// high, then a post-write wait (T_CLEAR for the clear command, T_CMD
// otherwise). rs/data are captured when go is seen and held until the next
// go. done pulses in the last wait cycle so the sequencer can issue the
// following byte in that same cycle with no gap.
module lcd_escritura
  import lcd_pkg::*;
#(
  parameter int T_E     = 12,
  parameter int T_CMD   = 2000,
  parameter int T_CLEAR = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       is_clear,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  output logic       done
);

  localparam logic [31:0] E_LAST   = 32'(T_E - 1);
  localparam logic [31:0] CMD_LAST = 32'(T_CMD - 1);
  localparam logic [31:0] CLR_LAST = 32'(T_CLEAR - 1);

  wr_phase_t   phase_reg, phase_next;
  logic [31:0] cnt_reg, cnt_next;
  logic        rs_reg;
  logic [7:0]  data_reg;
  logic        clear_reg;

  // Phase/counter state plus the byte latched at the start of each write.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg <= W_IDLE;
      cnt_reg   <= '0;
      rs_reg    <= 1'b0;
      data_reg  <= 8'h00;
      clear_reg <= 1'b0;
    end else begin
      phase_reg <= phase_next;
      cnt_reg   <= cnt_next;
      if (go) begin
        rs_reg    <= rs;
        data_reg  <= data;
        clear_reg <= is_clear;
      end
    end
  end

  // Walk setup -> E pulse -> wait; a new go always restarts at setup.
  always_comb begin
    phase_next = phase_reg;
    cnt_next   = cnt_reg;
    case (phase_reg)
      W_IDLE: begin
        phase_next = W_IDLE;
      end
      W_SETUP: begin
        phase_next = W_PULSE;
        cnt_next   = E_LAST;
      end
      W_PULSE: begin
        if (cnt_reg == '0) begin
          phase_next = W_WAIT;
          cnt_next   = clear_reg ? CLR_LAST : CMD_LAST;
        end else begin
          cnt_next = cnt_reg - 32'd1;
        end
      end
      W_WAIT: begin
        if (cnt_reg == '0) begin
          phase_next = W_IDLE;
        end else begin
          cnt_next = cnt_reg - 32'd1;
        end
      end
      default: phase_next = W_IDLE;
    endcase
    if (go) begin
      phase_next = W_SETUP;
      cnt_next   = '0;
    end
  end

  assign done     = (phase_reg == W_WAIT) && (cnt_reg == '0);
  assign lcd_e    = (phase_reg == W_PULSE);
  assign lcd_rs   = rs_reg;
  assign lcd_data = data_reg;

endmodule

// File: rtl/controlador_lcd.sv
// HD44780 16x2 controller in 8-bit mode. Waits out power-up, runs the init
// command list, then draws a frame (row-1 address, entries 0-15, row-2
// address, entries 16-31) and repeats it on request. Starts arriving during
// a frame are remembered once and replayed back-to-back.
// Optional build macro LCD_AUTO_REFRESH_EN: redraw automatically after
// REFRESH_CYC idle cycles.
module controlador_lcd
  import lcd_pkg::*;
#(
  parameter int T_POWERUP   = 750000,
  parameter int T_E         = 12,
  parameter int T_CMD       = 2000,
  parameter int T_CLEAR     = 82000,
  parameter int REFRESH_CYC = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [4:0] char_addr,
  input  logic [8:0] char_data,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       busy,
  output logic       init_done
);

  localparam logic [31:0] PU_LAST = 32'(T_POWERUP - 1);

  lcd_state_t  state_reg, state_next;
  logic [2:0]  init_idx_reg, init_idx_next;
  logic [4:0]  addr_reg, addr_next;
  logic        init_done_reg, init_done_next;
  logic        pending_reg, pending_next;
  logic [31:0] wait_cnt_reg;

  logic        go;
  logic        tx_rs;
  logic [7:0]  tx_data;
  logic        tx_clear;
  logic        wr_done;
  logic        in_frame;
  logic        count_en;
  logic        refresh_fire;

`ifdef LCD_AUTO_REFRESH_EN
  localparam logic [31:0] REF_LAST = 32'(REFRESH_CYC - 1);
  assign count_en     = (state_reg == S_POWERUP) || (state_reg == S_IDLE);
  assign refresh_fire = (state_reg == S_IDLE) && (wait_cnt_reg == REF_LAST);
`else
  logic unused_refresh;
  assign unused_refresh = ^REFRESH_CYC;
  assign count_en       = (state_reg == S_POWERUP);
  assign refresh_fire   = 1'b0;
`endif

  assign in_frame = (state_reg == S_L1_ADDR) || (state_reg == S_L1_CHAR) ||
                    (state_reg == S_L2_ADDR) || (state_reg == S_L2_CHAR);

  // Sequencer state, init index, table address and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_POWERUP;
      init_idx_reg  <= 3'd0;
      addr_reg      <= 5'd0;
      init_done_reg <= 1'b0;
      pending_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      init_idx_reg  <= init_idx_next;
      addr_reg      <= addr_next;
      init_done_reg <= init_done_next;
      pending_reg   <= pending_next;
    end
  end

  // Dwell counter: power-up delay, and idle refresh period when enabled;
  // restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      wait_cnt_reg <= '0;
    end else if (count_en) begin
      wait_cnt_reg <= wait_cnt_reg + 32'd1;
    end
  end

  // Next state and next byte. A transition into a sending state issues that
  // state's byte in the same cycle, so consecutive bytes abut exactly.
  // addr_reg always points at the next table entry to send.
  always_comb begin
    state_next     = state_reg;
    init_idx_next  = init_idx_reg;
    addr_next      = addr_reg;
    init_done_next = init_done_reg;
    pending_next   = pending_reg;
    go             = 1'b0;
    tx_rs          = 1'b0;
    tx_data        = 8'h00;

    if (start && in_frame) begin
      pending_next = 1'b1;
    end

    case (state_reg)
      S_POWERUP: begin
        if (wait_cnt_reg == PU_LAST) begin
          state_next    = S_INIT;
          init_idx_next = 3'd0;
          go            = 1'b1;
          tx_data       = init_cmd(3'd0);
        end
      end
      S_INIT: begin
        if (wr_done) begin
          go = 1'b1;
          if (init_idx_reg == INIT_LAST) begin
            init_done_next = 1'b1;
            state_next     = S_L1_ADDR;
            tx_data        = CMD_ROW1;
          end else begin
            init_idx_next = init_idx_reg + 3'd1;
            tx_data       = init_cmd(init_idx_reg + 3'd1);
          end
        end
      end
      S_L1_ADDR: begin
        if (wr_done) begin
          state_next = S_L1_CHAR;
          go         = 1'b1;
          tx_rs      = char_data[8];
          tx_data    = char_data[7:0];
          addr_next  = addr_reg + 5'd1;
        end
      end
      S_L1_CHAR: begin
        if (wr_done) begin
          go = 1'b1;
          if (addr_reg == ROW2_FIRST) begin
            state_next = S_L2_ADDR;
            tx_data    = CMD_ROW2;
          end else begin
            tx_rs     = char_data[8];
            tx_data   = char_data[7:0];
            addr_next = addr_reg + 5'd1;
          end
        end
      end
      S_L2_ADDR: begin
        if (wr_done) begin
          state_next = S_L2_CHAR;
          go         = 1'b1;
          tx_rs      = char_data[8];
          tx_data    = char_data[7:0];
          addr_next  = addr_reg + 5'd1;
        end
      end
      S_L2_CHAR: begin
        if (wr_done) begin
          if (addr_reg == 5'd0) begin
            // Address wrapped: frame complete. A start seen this very
            // cycle is treated like a pending one.
            if (pending_reg || start) begin
              pending_next = 1'b0;
              state_next   = S_L1_ADDR;
              go           = 1'b1;
              tx_data      = CMD_ROW1;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            go        = 1'b1;
            tx_rs     = char_data[8];
            tx_data   = char_data[7:0];
            addr_next = addr_reg + 5'd1;
          end
        end
      end
      S_IDLE: begin
        if (start || refresh_fire) begin
          state_next = S_L1_ADDR;
          go         = 1'b1;
          tx_data    = CMD_ROW1;
        end
      end
      default: begin
        state_next = S_POWERUP;
      end
    endcase

    tx_clear = go && !tx_rs && (tx_data == CMD_CLEAR);
  end

  lcd_escritura #(
    .T_E     (T_E),
    .T_CMD   (T_CMD),
    .T_CLEAR (T_CLEAR)
  ) u_escritura (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .rs       (tx_rs),
    .data     (tx_data),
    .is_clear (tx_clear),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_data (lcd_data),
    .done     (wr_done)
  );

  assign char_addr = addr_reg;
  assign lcd_rw    = 1'b0;
  assign busy      = (state_reg != S_IDLE);
  assign init_done = init_done_reg;

endmodule

// File: tb/tb_controlador_lcd.sv
// Self-checking bench for controlador_lcd. A monitor captures every byte at
// the rising edge of lcd_e; the expected byte stream (init list, then
// row-address + table entries per frame) and the byte spacing are derived
// from the panel protocol and compared against the captures.
module tb_controlador_lcd;

  localparam int T_POWERUP   = 20;
  localparam int T_E         = 2;
  localparam int T_CMD       = 5;
  localparam int T_CLEAR     = 10;
  localparam int REFRESH_CYC = 50;
  localparam int PER         = 1 + T_E + T_CMD;
  localparam int PER_CLR     = 1 + T_E + T_CLEAR;
  localparam int FRAME       = 34 * PER;
  localparam int IDLE_PROBE  = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [4:0] char_addr;
  logic [8:0] char_data;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_e, busy, init_done;

  logic [8:0] table_mem [32];
  assign char_data = table_mem[char_addr];

  controlador_lcd #(
    .T_POWERUP   (T_POWERUP),
    .T_E         (T_E),
    .T_CMD       (T_CMD),
    .T_CLEAR     (T_CLEAR),
    .REFRESH_CYC (REFRESH_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .char_addr (char_addr),
    .char_data (char_data),
    .lcd_data  (lcd_data),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .busy      (busy),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         t;
    logic       idone;
  } ev_t;

  ev_t  mon_q[$];
  logic e_prev = 1'b0;
  int   hi_cnt = 0;

  // Capture each byte as E rises and check the E pulse width as it falls.
  always @(negedge clk) begin
    if (reset) begin
      hi_cnt <= 0;
      e_prev <= lcd_e;
    end else begin
      if (lcd_e && !e_prev) mon_q.push_back('{lcd_rs, lcd_data, cyc, init_done});
      if (lcd_e) begin
        hi_cnt <= hi_cnt + 1;
      end else if (e_prev) begin
        check_eq("e_width", 32'(hi_cnt), 32'(T_E));
        hi_cnt <= 0;
      end
      e_prev <= lcd_e;
    end
  end

  ev_t  prev_ev;
  ev_t  last_ev;
  logic have_prev = 1'b0;
  logic stalled = 1'b0;

  // Pop the next captured byte, compare it and its spacing from the previous one.
  task automatic expect_byte(input string tag, input logic [8:0] exp);
    ev_t e;
    int  waited = 0;
    int  budget;
    budget = stalled ? 1 : 400;
    while (mon_q.size() == 0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (mon_q.size() == 0) begin
      stalled = 1'b1;
      check_eq({tag, "_timeout"}, 32'(mon_q.size()), 32'd1);
      return;
    end
    e = mon_q.pop_front();
    check_eq(tag, 32'({e.rs, e.data}), 32'(exp));
    if (have_prev)
      check_eq({tag, "_gap"}, 32'(e.t - prev_ev.t),
               ({prev_ev.rs, prev_ev.data} == 9'h001) ? 32'(PER_CLR) : 32'(PER));
    prev_ev   = e;
    last_ev   = e;
    have_prev = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reference frame: row-1 address, entries 0..15, row-2 address, entries 16..31.
  task automatic expect_frame(input string tag, input int nbytes, input int p1, input int p2);
    logic [8:0] exp;
    for (int i = 0; i < nbytes; i++) begin
      if (i == 0)       exp = 9'h080;
      else if (i <= 16) exp = table_mem[5'(i - 1)];
      else if (i == 17) exp = 9'h0C0;
      else              exp = table_mem[5'(i - 2)];
      expect_byte($sformatf("%s_b%0d", tag, i), exp);
      if (i == p1 || i == p2) pulse_start();
    end
  endtask

  task automatic expect_init(input string tag);
    logic [8:0] init_list [6];
    init_list = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006};
    for (int i = 0; i < 6; i++) expect_byte($sformatf("%s_init%0d", tag, i), init_list[i]);
    check_eq({tag, "_init_done_at_last_cmd"}, 32'(last_ev.idone), 32'd0);
  endtask

  task automatic wait_busy_low(input string tag, input int t0, input int exp_dt);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(cyc - t0), 32'(exp_dt));
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 32; i++) table_mem[i] = {1'b1, 8'(8'h41 + i)};
  endtask

  task automatic idle_probe(input string tag);
    repeat (IDLE_PROBE) @(negedge clk);
    check_eq({tag, "_no_bytes"}, 32'(mon_q.size()), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int s;
    int e_hi;
    int t_fall;

    fill_ramp();

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_e", 32'(lcd_e), 32'd0);
    check_eq("rst_rs", 32'(lcd_rs), 32'd0);
    check_eq("rst_rw", 32'(lcd_rw), 32'd0);
    check_eq("rst_data", 32'(lcd_data), 32'd0);
    check_eq("rst_addr", 32'(char_addr), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd1);
    check_eq("rst_init_done", 32'(init_done), 32'd0);

    // Power-up: E stays low; a start here must be ignored
    reset = 1'b0;
    e_hi = 0;
    for (int i = 0; i < T_POWERUP; i++) begin
      start = (i == 5);
      @(negedge clk);
      e_hi += int'(lcd_e);
    end
    start = 1'b0;
    check_eq("powerup_e_quiet", 32'(e_hi), 32'd0);

    expect_init("pu");
    expect_frame("auto", 1, -1, -1);
    check_eq("init_done_at_frame", 32'(last_ev.idone), 32'd1);
    expect_frame_rest();
    wait_busy_low("auto_busy_fall", last_ev.t, PER - 1);
    idle_probe("after_auto");

    // Randomized tables, one start-triggered frame each
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 32; i++) table_mem[i] = 9'($urandom_range(0, 511));
      if (k == 0) table_mem[5] = 9'h0C0;
      repeat ($urandom_range(1, 5)) @(negedge clk);
      s = cyc;
      pulse_start();
      have_prev = 1'b0;
      expect_frame($sformatf("rnd%0d", k), 34, -1, -1);
      wait_busy_low($sformatf("rnd%0d_busy_fall", k), s, FRAME + 1);
    end

    // Two starts during a frame -> exactly one extra back-to-back frame
    fill_ramp();
    repeat (2) @(negedge clk);
    s = cyc;
    pulse_start();
    have_prev = 1'b0;
    expect_frame("dbl_a", 34, 5, 20);
    expect_frame("dbl_b", 34, -1, -1);
    wait_busy_low("dbl_busy_fall", s, 2 * FRAME + 1);
    idle_probe("after_dbl");

    // Reset in the middle of a frame, then full replay
    s = cyc;
    pulse_start();
    have_prev = 1'b0;
    expect_frame("rst", 11, -1, -1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_e", 32'(lcd_e), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd1);
    check_eq("midrst_init_done", 32'(init_done), 32'd0);
    check_eq("midrst_addr", 32'(char_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mon_q.delete();
    have_prev = 1'b0;
    expect_init("replay");
    expect_frame("replay", 34, -1, -1);
    check_eq("replay_init_done", 32'(init_done), 32'd1);
    wait_busy_low("replay_busy_fall", last_ev.t, PER - 1);
    t_fall = cyc;

`ifdef LCD_AUTO_REFRESH_EN
    begin
      int n = 0;
      while (busy !== 1'b1 && n < 500) begin
        @(negedge clk);
        n++;
      end
      check_eq("refresh_idle_len", 32'(cyc - t_fall), 32'(REFRESH_CYC));
      have_prev = 1'b0;
      expect_frame("refresh", 34, -1, -1);
    end
`else
    repeat (300) @(negedge clk);
    check_eq("stay_idle_bytes", 32'(mon_q.size()), 32'd0);
    check_eq("stay_idle_busy", 32'(busy), 32'd0);
    check_eq("stay_idle_len", 32'(cyc - t_fall), 32'd300);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Remaining 33 bytes of a frame whose first byte was already consumed.
  task automatic expect_frame_rest();
    logic [8:0] exp;
    for (int i = 1; i < 34; i++) begin
      if (i <= 16)      exp = table_mem[5'(i - 1)];
      else if (i == 17) exp = 9'h0C0;
      else              exp = table_mem[5'(i - 2)];
      expect_byte($sformatf("auto_b%0d", i), exp);
    end
  endtask

endmodule
